// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// Locks onto one requester per message, with a per-grant byte cap (MAX_BURST).
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [8*N_REQ-1:0]       i_req_data,
  input  logic [N_REQ-1:0]         i_req_last,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_locked
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [IDW:0]       N_REQ_W     = (IDW + 1)'(N_REQ);
  localparam logic [BCW-1:0]     MAX_BURST_W = BCW'(MAX_BURST);
  localparam logic [N_REQ-1:0]   ONE_HOT0    = N_REQ'(1);
  localparam logic [IDW-1:0]     IDX_ONE     = IDW'(1);
  localparam logic [BCW-1:0]     BURST_ONE   = BCW'(1);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [BCW-1:0]   burst_cnt_r;
  logic             last_r;

  logic [N_REQ-1:0] eligible_s;
  logic [N_REQ-1:0] cand_s;
  logic [IDW:0]     pick_s;
  logic [IDW-1:0]   sel_s;
  logic             found_s;
  logic             take_s;
  logic [7:0]       sel_data_s;
  logic             release_s;

  // (a + b) mod N_REQ for indices already below N_REQ
  function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    logic [IDW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= N_REQ_W) begin
      sum = sum - N_REQ_W;
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  // Returns {found, index} of the first candidate at or above ptr, wrapping; scanning
  // downward in offset lets the smallest offset overwrite the others.
  function automatic logic [IDW:0] pick(input logic [N_REQ-1:0] cand, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] idx;
    logic [IDW:0]   res;
    res = {(IDW + 1){1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = add_mod(ptr, IDW'(i));
      if (cand[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Candidate selection and the combinational accept strobe
  always_comb begin
    if (o_locked) begin
      eligible_s = o_grant;
    end else begin
      eligible_s = {N_REQ{1'b1}};
    end
    cand_s     = i_req_valid & eligible_s;
    pick_s     = pick(cand_s, rr_ptr_r);
    found_s    = pick_s[IDW];
    sel_s      = pick_s[IDW-1:0];
    take_s     = (state_r == ARB) && found_s && !i_tx_busy && !rst;
    sel_data_s = i_req_data[{sel_s, 3'b000} +: 8];
    release_s  = last_r || (burst_cnt_r == MAX_BURST_W);
    if (take_s) begin
      o_req_ready = ONE_HOT0 << sel_s;
    end else begin
      o_req_ready = {N_REQ{1'b0}};
    end
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ARB;
      o_tx_start  <= 1'b0;
      o_tx_data   <= 8'h00;
      o_grant     <= {N_REQ{1'b0}};
      o_grant_id  <= {IDW{1'b0}};
      o_locked    <= 1'b0;
      rr_ptr_r    <= {IDW{1'b0}};
      burst_cnt_r <= {BCW{1'b0}};
      last_r      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state_r)
        ARB: begin
          if (take_s) begin
            o_tx_data  <= sel_data_s;
            o_grant    <= ONE_HOT0 << sel_s;
            o_grant_id <= sel_s;
            o_locked   <= 1'b1;
            last_r     <= i_req_last[sel_s];
            if (burst_cnt_r != MAX_BURST_W) begin
              burst_cnt_r <= burst_cnt_r + BURST_ONE;
            end else begin
              burst_cnt_r <= burst_cnt_r;
            end
            o_tx_start <= 1'b1;
            state_r    <= SEND;
          end else begin
            state_r <= ARB;
          end
        end
        SEND: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            state_r <= ARB;
            // o_grant_id deliberately keeps the last owner after release
            if (release_s) begin
              o_locked    <= 1'b0;
              o_grant     <= {N_REQ{1'b0}};
              burst_cnt_r <= {BCW{1'b0}};
              rr_ptr_r    <= add_mod(o_grant_id, IDX_ONE);
            end else begin
              o_locked <= o_locked;
            end
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters, a uart_tx timing model,
// and a monitor that pops expected (owner, byte) pairs on each start pulse.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int MB    = 4;
  localparam int FRAME = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           tx_done;
  logic [N-1:0]   grant;
  logic [1:0]     grant_id;
  logic           locked;

  int total = 0;
  int bad   = 0;

  logic [8:0] rq [N][$];
  logic [9:0] exp_q [$];

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_grant(grant), .o_grant_id(grant_id), .o_locked(locked)
  );

  always #5 clk = ~clk;

  // Requesters: present queue heads at negedge, pop on handshake seen just before posedge
  initial begin
    logic [N-1:0] acc;
    acc = {N{1'b0}};
    req_valid = {N{1'b0}};
    req_data = {(8*N){1'b0}};
    req_last = {N{1'b0}};
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (acc[k] && rq[k].size() > 0) rq[k].delete(0);
        if (rq[k].size() > 0) begin
          req_valid[k] = 1'b1;
          req_data[8*k +: 8] = rq[k][0][7:0];
          req_last[k] = rq[k][0][8];
        end else begin
          req_valid[k] = 1'b0;
        end
      end
      #4;
      acc = req_valid & req_ready;
    end
  end

  // Transmitter model: busy one cycle after start, done after FRAME busy cycles
  initial begin
    int cnt;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        @(posedge clk); #1;
        tx_busy = 1'b1;
        cnt = 0;
        while (cnt < FRAME && !rst) begin
          @(posedge clk); #1;
          cnt++;
        end
        tx_busy = 1'b0;
        if (!rst) begin
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
        end
      end
    end
  end

  // Monitor: ready legality every cycle, scoreboard pop on every start pulse
  initial begin
    logic [9:0]   e;
    logic [N-1:0] eg;
    logic         viol;
    forever begin
      @(negedge clk);
      viol = ((req_ready & (req_ready - 1'b1)) != {N{1'b0}}) ||
             ((req_ready != {N{1'b0}}) && (tx_busy || tx_done || tx_start || rst)) ||
             (locked && ((req_ready & ~grant) != {N{1'b0}})) ||
             ((req_ready & ~req_valid) != {N{1'b0}});
      total++;
      if (viol) begin
        bad++;
        $display("FAIL ready_legal t=%0t: ready=%b valid=%b grant=%b busy=%b", $time, req_ready, req_valid, grant, tx_busy);
      end
      if (tx_start) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start t=%0t: got id=%0d data=%h, none expected", $time, grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          eg = N'(1) << e[9:8];
          if ({grant, grant_id, tx_data} !== {eg, e}) begin
            bad++;
            $display("FAIL start_byte t=%0t: got grant=%b id=%0d data=%h, want grant=%b id=%0d data=%h",
                     $time, grant, grant_id, tx_data, eg, e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  function automatic bit queues_empty();
    bit r;
    r = 1'b1;
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (queues_empty() && exp_q.size() == 0 && !locked && !tx_busy && !tx_done && !tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) rq[k].delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    rq[k].push_back({l, d});
    exp_q.push_back({2'(k), d});
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({tx_start, tx_data, req_ready, grant, grant_id, locked} !== {1'b0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got start=%b data=%h ready=%b grant=%b id=%0d locked=%b, want all zero",
               tx_start, tx_data, req_ready, grant, grant_id, locked);
    end
    rq[1].push_back({1'b1, 8'h99});
    @(negedge clk); #1;
    total++;
    if (req_ready !== 4'h0) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    rq[1].delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_idle: got timeout want idle"); end
    total++;
    if ({grant, grant_id, locked} !== {4'h0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL single_release: got grant=%b id=%0d locked=%b want 0000/0/0", grant, grant_id, locked);
    end
    // pointer is now 1, so requester 1 beats requester 0
    push(1, 8'h51, 1'b1);
    push(0, 8'h50, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_ptr_idle: got timeout want idle"); end
  endtask

  task automatic test_two_req();
    bit ok;
    do_reset();
    push(0, 8'h10, 1'b0);
    push(0, 8'h11, 1'b1);
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL two_idle: got timeout want idle"); end
    total++;
    if (grant_id !== 2'd2) begin bad++; $display("FAIL two_last_id: got %0d want 2", grant_id); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    push(3, 8'h30, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_first_idle: got timeout want idle"); end
    push(0, 8'h01, 1'b1);
    push(3, 8'h31, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_idle: got timeout want idle"); end
  endtask

  task automatic test_burst();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) rq[1].push_back({1'b0, 8'hA0 + 8'(i)});
    rq[1].push_back({1'b0, 8'hA4});
    rq[1].push_back({1'b1, 8'hA5});
    rq[2].push_back({1'b1, 8'hB0});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 8'hA0 + 8'(i)});
    exp_q.push_back({2'd2, 8'hB0});
    exp_q.push_back({2'd1, 8'hA4});
    exp_q.push_back({2'd1, 8'hA5});
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL burst_idle: got timeout want idle"); end
  endtask

  task automatic test_hold();
    bit ok;
    do_reset();
    push(2, 8'h60, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rq[2].size() == 0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL hold_accept: got timeout want first byte accepted"); end
    rq[0].push_back({1'b1, 8'h70});
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++;
      if (req_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready0 cycle %0d: got %b want 0", c, req_ready[0]);
      end
    end
    total++;
    if ({locked, grant_id} !== {1'b1, 2'd2}) begin
      bad++;
      $display("FAIL hold_lock: got locked=%b id=%0d want 1/2", locked, grant_id);
    end
    push(2, 8'h61, 1'b1);
    exp_q.push_back({2'd0, 8'h70});
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hold_idle: got timeout want idle"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push(2, 8'hC8, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL mid_pre_idle: got timeout want idle"); end
    // pointer is now 3; requester 1 starts a 3-byte message
    push(1, 8'hC0, 1'b0);
    push(1, 8'hC1, 1'b0);
    rq[1].push_back({1'b1, 8'hC2});
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL mid_second_start: got timeout want start"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({tx_start, tx_data, req_ready, grant, grant_id, locked} !== {1'b0, 8'h00, 4'h0, 4'h0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_values: got start=%b data=%h ready=%b grant=%b id=%0d locked=%b, want all zero",
               tx_start, tx_data, req_ready, grant, grant_id, locked);
    end
    for (int k = 0; k < N; k++) rq[k].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    // fresh pointer 0: requester 1 must beat requester 3
    push(1, 8'hE1, 1'b1);
    push(3, 8'hE3, 1'b1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL mid_after_idle: got timeout want idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_req();
    test_wrap();
    test_burst();
    test_hold();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte-stream requesters. Each requester offers bytes with a valid/ready handshake and marks message ends with `last`. The arbiter locks onto one requester for a whole message, so messages are never interleaved, with a byte cap against hogging. It sits directly upstream of `uart_tx`: it drives that block's start/data inputs and consumes its busy/done outputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `MAX_BURST`, 16: maximum bytes sent per grant before the lock is force-released, ≥1.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `i_req_valid`  input  N_REQ  requester k has a byte on `i_req_data[8k+7:8k]`.
- `i_req_data`  input  8*N_REQ  flattened request bytes.
- `i_req_last`  input  N_REQ  byte from requester k is the final byte of its message.
- `o_req_ready`  output  N_REQ  one-hot accept strobe; transfer occurs when valid and ready are both high at a clock edge.
- `o_tx_data`  output  8  byte to transmitter.
- `o_tx_start`  output  1  one-cycle start pulse to transmitter.
- `i_tx_busy`  input  1  transmitter busy.
- `i_tx_done`  input  1  transmitter one-cycle done pulse.
- `o_grant`  output  N_REQ  one-hot current owner; zero when unowned.
- `o_grant_id`  output  $clog2(N_REQ)  index of current or most recent owner.
- `o_locked`  output  1  a message is in progress; only the owner is eligible.

## Operation
- Reset values: state ARB, `o_tx_start`=0, `o_tx_data`=0, `o_req_ready`=0, `o_grant`=0, `o_grant_id`=0, `o_locked`=0, RR pointer=0, burst count=0. The asynchronous reset is honoured mid-message: the lock is dropped and the byte in flight is abandoned. The downstream transmitter is reset by the same `rst`.
- FSM states are ARB, SEND and WAIT.
- **ARB**
  - The eligible set is the owner only when `o_locked`=1. Otherwise it is all requesters.
  - The selected requester is the first valid eligible index scanning upward from the RR pointer, with wrap N_REQ-1→0.
  - `o_req_ready` is high (combinational) for the selected index only when a candidate exists and `i_tx_busy`=0.
  - On a transfer:
    - Capture the byte into `o_tx_data`.
    - Set `o_grant`/`o_grant_id` to the selected index.
    - Set `o_locked`=1 and increment the burst count.
    - Go to SEND.
  - With no candidate, remain in ARB. A locked owner with no valid byte keeps the lock, and other requesters wait.
- **SEND**
  - `o_tx_start`=1 for exactly this one cycle; `o_tx_data` is held stable.
  - Always go to WAIT.
- **WAIT**
  - Wait for `i_tx_done`=1, then go to ARB.
  - At that edge, release the lock if the transferred byte had `last`=1 or the burst count equals MAX_BURST. Release means:
    - `o_locked`=0, `o_grant`=0, burst count=0.
    - RR pointer = owner+1 mod N_REQ.
    - `o_grant_id` retains the last owner.
- `i_tx_done` outside WAIT is ignored.
- `o_tx_data` holds its last value between bytes.
- The burst counter width is $clog2(MAX_BURST+1) and it never wraps.
- A requester must not change data/last while valid is high and not yet accepted. The arbiter does not check this.

## Timing
- Byte accept (ARB edge) → `o_tx_start` high the next cycle.
- Transmitter busy starts one cycle after start. Done pulses after 10 bit periods plus 1 cycle.
- Done pulse → earliest next `o_req_ready` is the cycle after the done edge (ARB).
- Minimum spacing between start pulses is one transmitter frame plus 3 cycles.
- `o_req_ready` is never high in SEND or WAIT, and never on more than one bit.
- Simultaneous valid on several requesters when unlocked: the lowest index at or above the pointer wins.
- Valid arriving on a non-owner while locked is held off until release.

## Test plan
- Single requester 0 sends 0x41,0x42,0x43 with last on 0x43 → three start pulses carrying those bytes in order. `o_locked` drops after the third done, and the pointer becomes 1.
- Requesters 0 and 2 both valid from reset, each with a 2-byte message → sequence 0,0,2,2 with no interleaving; `o_grant_id` goes 0 then 2.
- Requester 3 finishes a message, then requesters 0 and 3 are both valid → requester 0 is granted (pointer wrapped to 0).
- MAX_BURST=4 with requester 1 sending 6 bytes without last, and requester 2 waiting → bytes 1,1,1,1,2…,1,1. The lock is released after the 4th done.
- Locked owner drops valid for 50 cycles mid-message while requester 0 is valid → no ready to requester 0 until the owner sends last.
- Assert `rst` during WAIT of byte 2 of a 3-byte message → all outputs go to reset values immediately. After release, fresh arbitration starts from pointer 0, and no stale start pulse occurs.
